// File: rtl/clk_gen_pkg.sv
// Shared mode and state encodings for the multi-mode clock generator.
package clk_gen_pkg;

   typedef enum logic [1:0] {
      MODE_SLOW  = 2'b00,
      MODE_FAST  = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_PAUSE = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HIGH = 2'b01,
      ST_LOW  = 2'b10
   } state_t;

   function automatic logic is_free_run(mode_t m);
      return (m == MODE_SLOW) || (m == MODE_FAST);
   endfunction

endpackage

// File: rtl/step_sync.sv
// Two-flop synchroniser for the step button followed by a registered
// rising-edge detector producing a one-cycle pulse.
module step_sync (
   input  logic clk_in,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // NOTE: sequential state is always updated with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbour, as real hardware does.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
         pulse  <= sync_q & ~prev_q;
      end
   end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-mode clock divider: free-running slow/fast, single-step and pause,
// with mode changes applied only at clk_out period boundaries.
module clk_gen_multi #(
   parameter int CNT_W     = 32,
   parameter int HALF_FAST = 31,
   parameter int HALF_SLOW = 2500001
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [1:0] mode_sel,
   input  logic       step,
   output logic       clk_out,
   output logic       tick,
   output logic [1:0] mode_act
);

   import clk_gen_pkg::*;

   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(HALF_FAST - 1);
   localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(HALF_SLOW - 1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d, sel;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             boot_q;
   logic             step_pulse;
   logic             at_last;

   step_sync u_step_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .din    (step),
      .pulse  (step_pulse)
   );

   assign sel      = mode_t'(mode_sel);
   // Step pulses share the fast half-period; only SLOW uses the long compare.
   assign cnt_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
   assign at_last  = (cnt_q == cnt_last);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOW;
         mode_q  <= MODE_SLOW;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         boot_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         boot_q  <= 1'b0;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;

      case (state_q)
         ST_LOW: begin
            if (boot_q && !is_free_run(sel)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (at_last) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               clk_d   = 1'b1;
               tick_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HIGH: begin
            if (at_last) begin
               cnt_d   = '0;
               clk_d   = 1'b0;
               mode_d  = sel;
               state_d = is_free_run(sel) ? ST_LOW : ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            // A firing step keeps STEP active so its high phase uses HALF_FAST.
            if (mode_q == MODE_STEP && step_pulse) begin
               state_d = ST_HIGH;
               clk_d   = 1'b1;
               tick_d  = 1'b1;
            end else begin
               mode_d = sel;
               if (is_free_run(sel)) state_d = ST_LOW;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase

      if (boot_q) mode_d = sel;
   end

   assign clk_out  = clk_q;
   assign tick     = tick_q;
   assign mode_act = mode_q;

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle to a reference model.
module tb_clk_gen_multi;

   localparam int HALF_FAST = 3;
   localparam int HALF_SLOW = 8;

   logic       clk_in = 1'b0;
   logic       rst;
   logic [1:0] mode_sel;
   logic       step;
   logic       clk_out;
   logic       tick;
   logic [1:0] mode_act;

   int n_tests = 0;
   int n_fail  = 0;

   clk_gen_multi #(
      .CNT_W     (16),
      .HALF_FAST (HALF_FAST),
      .HALF_SLOW (HALF_SLOW)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .mode_sel (mode_sel),
      .step     (step),
      .clk_out  (clk_out),
      .tick     (tick),
      .mode_act (mode_act)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: edges left in the current half-period, a sample history
   // of the step input, and the active mode, all advanced once per clock edge.
   typedef struct packed {
      logic        out;
      logic        tick;
      logic [1:0]  mode;
      logic [31:0] left;
      logic        idle;
      logic        boot;
   } model_t;

   model_t     m;
   logic [3:0] hist;

   function automatic logic [31:0] half_of(logic [1:0] mode);
      return (mode == 2'b00) ? 32'(HALF_SLOW) : 32'(HALF_FAST);
   endfunction

   function automatic logic free_run(logic [1:0] mode);
      return mode[1] == 1'b0;
   endfunction

   function automatic model_t model_reset();
      model_t r;
      r.out  = 1'b0;
      r.tick = 1'b0;
      r.mode = 2'b00;
      r.left = 32'(HALF_SLOW);
      r.idle = 1'b0;
      r.boot = 1'b1;
      return r;
   endfunction

   function automatic model_t model_next(model_t s, logic [1:0] sel, logic pulse);
      model_t n = s;
      n.tick = 1'b0;
      n.boot = 1'b0;
      if (s.idle) begin
         if (s.mode == 2'b10 && pulse) begin
            n.out  = 1'b1;
            n.tick = 1'b1;
            n.idle = 1'b0;
            n.left = 32'(HALF_FAST);
         end else begin
            n.mode = sel;
            if (free_run(sel)) begin
               n.idle = 1'b0;
               n.left = half_of(sel);
            end
         end
      end else if (s.boot) begin
         n.mode = sel;
         if (free_run(sel)) n.left = half_of(sel) - 1;
         else               n.idle = 1'b1;
      end else begin
         n.left = s.left - 1;
         if (n.left == 0) begin
            if (s.out) begin
               n.out  = 1'b0;
               n.mode = sel;
               if (free_run(sel)) n.left = half_of(sel);
               else               n.idle = 1'b1;
            end else begin
               n.out  = 1'b1;
               n.tick = 1'b1;
               n.left = half_of(s.mode);
            end
         end
      end
      return n;
   endfunction

   // A step rise sampled at edge k becomes a pulse acted on at edge k+3.
   always @(posedge clk_in or posedge rst) begin
      if (rst) begin
         m    <= model_reset();
         hist <= '0;
      end else begin
         m    <= model_next(m, mode_sel, hist[2] & ~hist[3]);
         hist <= {hist[2:0], step};
      end
   end

   always @(negedge clk_in) begin
      check("cmp clk_out",  32'(clk_out),  32'(m.out));
      check("cmp tick",     32'(tick),     32'(m.tick));
      check("cmp mode_act", 32'(mode_act), 32'(m.mode));
   end

   task automatic measure(input logic level, output int len, output int ticks);
      len   = 0;
      ticks = 0;
      while (clk_out === level && len < 200) begin
         len++;
         ticks += int'(tick);
         @(negedge clk_in);
         #1;
      end
   endtask

   task automatic step_trial(input logic [15:0] pattern, output int first_hi,
                             output int n_hi, output int n_tick);
      first_hi = -1;
      n_hi     = 0;
      n_tick   = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_in);
         step = pattern[i];
         #1;
         if (clk_out === 1'b1 && first_hi < 0) first_hi = i;
         n_hi   += int'(clk_out);
         n_tick += int'(tick);
      end
      step = 1'b0;
   endtask

   task automatic quiet_window(input int cycles, output int n_hi, output int n_tick);
      n_hi   = 0;
      n_tick = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_in);
         #1;
         n_hi   += int'(clk_out);
         n_tick += int'(tick);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, ticks, first_hi, n_hi, n_tick;
      rst      = 1'b1;
      mode_sel = 2'b00;
      step     = 1'b0;
      repeat (3) @(negedge clk_in);
      #1;
      check("reset clk_out",  32'(clk_out),  32'd0);
      check("reset tick",     32'(tick),     32'd0);
      check("reset mode_act", 32'(mode_act), 32'd0);

      // Slow mode from reset: 8 low, 8 high with one tick, 8 low.
      @(negedge clk_in);
      rst = 1'b0;
      #1;
      measure(1'b0, len, ticks);
      check("slow first low len", 32'(len), 32'd8);
      check("slow low ticks",     32'(ticks), 32'd0);
      measure(1'b1, len, ticks);
      check("slow high len",   32'(len), 32'd8);
      check("slow high ticks", 32'(ticks), 32'd1);
      measure(1'b0, len, ticks);
      check("slow second low len", 32'(len), 32'd8);

      // Switch to FAST in the third cycle of a high phase.
      repeat (2) @(negedge clk_in);
      mode_sel = 2'b01;
      #1;
      measure(1'b1, len, ticks);
      check("slow high remainder", 32'(len), 32'd6);
      check("mode_act after fall", 32'(mode_act), 32'd1);
      measure(1'b0, len, ticks);
      check("fast low len", 32'(len), 32'd3);
      measure(1'b1, len, ticks);
      check("fast high len",   32'(len), 32'd3);
      check("fast high ticks", 32'(ticks), 32'd1);

      // FAST to PAUSE while high: the high phase completes, then stays low.
      measure(1'b0, len, ticks);
      @(negedge clk_in);
      mode_sel = 2'b11;
      #1;
      measure(1'b1, len, ticks);
      check("pause high remainder", 32'(len), 32'd2);
      quiet_window(20, n_hi, n_tick);
      check("pause high cycles",    32'(n_hi), 32'd0);
      check("pause ticks",          32'(n_tick), 32'd0);
      check("pause mode_act",       32'(mode_act), 32'd3);

      // Step presses are ignored while paused.
      step_trial(16'h001f, first_hi, n_hi, n_tick);
      check("paused step high cycles", 32'(n_hi), 32'd0);

      // STEP mode: held press, then a second rise during the pulse.
      @(negedge clk_in);
      mode_sel = 2'b10;
      repeat (2) @(negedge clk_in);
      #1;
      check("step mode_act", 32'(mode_act), 32'd2);
      step_trial(16'h001f, first_hi, n_hi, n_tick);
      check("step latency",      32'(first_hi), 32'd4);
      check("step high cycles",  32'(n_hi),     32'd3);
      check("step ticks",        32'(n_tick),   32'd1);
      step_trial(16'h0005, first_hi, n_hi, n_tick);
      check("double step latency",     32'(first_hi), 32'd4);
      check("double step high cycles", 32'(n_hi),     32'd3);
      check("double step ticks",       32'(n_tick),   32'd1);

      // Asynchronous reset in the middle of a FAST high phase.
      @(negedge clk_in);
      mode_sel = 2'b01;
      #1;
      measure(1'b0, len, ticks);
      check("fast rise tick", 32'(tick), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async rst clk_out",  32'(clk_out),  32'd0);
      check("async rst tick",     32'(tick),     32'd0);
      check("async rst mode_act", 32'(mode_act), 32'd0);
      @(negedge clk_in);
      rst = 1'b0;
      #1;
      check("mode_act before first edge", 32'(mode_act), 32'd0);
      @(negedge clk_in);
      #1;
      check("mode_act after first edge", 32'(mode_act), 32'd1);

      // Randomized stimulus, checked every cycle against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 39) == 0) mode_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0)  step = ~step;
         if ($urandom_range(0, 599) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk_in);
            #2 rst = 1'b0;
         end
      end

      repeat (2) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
